alu_issue_stage: RTL and testbench

//  Producer side of the ALU interface: accepts 32-bit RV32I integer instructions plus

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_op_decode.sv | 65 ++++++
 rtl/alu_issue_stage.sv | 112 +++++++++++
 tb/tb_alu_issue_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU-interface definitions: opcode encodings, RV32I decode constants and the
// decoded-instruction payload carried through the issue stage.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_OP_NONE = 4'b0000;
    localparam logic [3:0] ALU_OP_ADD  = 4'b0001;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0010;
    localparam logic [3:0] ALU_OP_AND  = 4'b0011;
    localparam logic [3:0] ALU_OP_OR   = 4'b0100;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] operand1;
        logic [XLEN-1:0] operand2;
        logic [3:0]      alu_opcode;
        logic [4:0]      rd;
        logic            illegal;
    } issue_payload_t;

    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode of the ALU subset into an issue payload; anything outside
// the subset is flagged illegal and passed on with opcode NONE and the rs2 value.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output issue_payload_t  payload
);

    logic [6:0] opcode_s;
    logic [6:0] funct7_s;
    logic [2:0] funct3_s;
    logic [3:0] op_s;
    logic       unused_rs1_idx_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    // Register indices are resolved upstream; only the values arrive here.
    assign unused_rs1_idx_s = ^instr[19:15];

    // Select the ALU operation from opcode/funct fields.
    always_comb begin
        op_s = ALU_OP_NONE;
        case (opcode_s)
            OPC_OP: begin
                case ({funct7_s, funct3_s})
                    {F7_BASE, F3_ADD_SUB}: op_s = ALU_OP_ADD;
                    {F7_ALT,  F3_ADD_SUB}: op_s = ALU_OP_SUB;
                    {F7_BASE, F3_AND}:     op_s = ALU_OP_AND;
                    {F7_BASE, F3_OR}:      op_s = ALU_OP_OR;
                    {F7_BASE, F3_XOR}:     op_s = ALU_OP_XOR;
                    default:               op_s = ALU_OP_NONE;
                endcase
            end
            OPC_OP_IMM: begin
                case (funct3_s)
                    F3_ADD_SUB: op_s = ALU_OP_ADD;
                    F3_AND:     op_s = ALU_OP_AND;
                    F3_OR:      op_s = ALU_OP_OR;
                    F3_XOR:     op_s = ALU_OP_XOR;
                    default:    op_s = ALU_OP_NONE;
                endcase
            end
            default: op_s = ALU_OP_NONE;
        endcase
    end

    // Assemble the payload; the immediate replaces rs2 only for a decoded I-type op.
    always_comb begin
        payload            = '0;
        payload.operand1   = rs1_val;
        payload.rd         = instr[11:7];
        payload.alu_opcode = op_s;
        payload.illegal    = (op_s == ALU_OP_NONE);
        if ((opcode_s == OPC_OP_IMM) && (op_s != ALU_OP_NONE)) begin
            payload.operand2 = sext_imm12(instr[31:20]);
        end else begin
            payload.operand2 = rs2_val;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage feeding the ALU: decode, then a main/skid register pair so that
// in_ready is a flop and never depends combinationally on out_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_operand1,
    output logic [WIDTH-1:0] out_operand2,
    output logic [3:0]       out_alu_opcode,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    issue_payload_t   dec_s;
    issue_payload_t   main_r;
    issue_payload_t   main_n_s;
    issue_payload_t   skid_r;
    issue_payload_t   skid_n_s;
    logic             main_valid_r;
    logic             main_valid_n_s;
    logic             skid_valid_r;
    logic             skid_valid_n_s;
    logic             in_ready_r;
    logic             accept_s;
    logic [CNT_W-1:0] illegal_count_r;

    alu_op_decode u_decode (
        .instr   (in_instr),
        .rs1_val (in_rs1_val),
        .rs2_val (in_rs2_val),
        .payload (dec_s)
    );

    assign accept_s = in_valid && in_ready_r;

    // Next-state of the main/skid pair; the skid only fills when main is stalled.
    always_comb begin
        main_n_s       = main_r;
        main_valid_n_s = main_valid_r;
        skid_n_s       = skid_r;
        skid_valid_n_s = skid_valid_r;
        if (accept_s && (!main_valid_r || out_ready)) begin
            main_valid_n_s = 1'b1;
            if (skid_valid_r) begin
                main_n_s = skid_r;
                skid_n_s = dec_s;
            end else begin
                main_n_s = dec_s;
            end
        end else if (accept_s) begin
            skid_n_s       = dec_s;
            skid_valid_n_s = 1'b1;
        end else if (out_ready && skid_valid_r) begin
            main_n_s       = skid_r;
            skid_valid_n_s = 1'b0;
        end else if (out_ready) begin
            main_valid_n_s = 1'b0;
        end else begin
            main_valid_n_s = main_valid_r;
        end
    end

    // Storage registers; in_ready is precomputed from the next skid occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_r       <= main_n_s;
            skid_r       <= skid_n_s;
            main_valid_r <= main_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
            in_ready_r   <= !skid_valid_n_s;
        end
    end

    // Saturating debug count of illegal instructions, counted at input accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count_r <= '0;
        end else if (accept_s && dec_s.illegal && (illegal_count_r != {CNT_W{1'b1}})) begin
            illegal_count_r <= illegal_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            illegal_count_r <= illegal_count_r;
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = main_valid_r;
    assign out_operand1   = main_r.operand1;
    assign out_operand2   = main_r.operand2;
    assign out_alu_opcode = main_r.alu_opcode;
    assign out_rd         = main_r.rd;
    assign out_illegal    = main_r.illegal;
    assign illegal_count  = illegal_count_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus randomized checks of alu_issue_stage against a queue-based reference;
// a second instance with a 2-bit counter exercises counter saturation.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_rs1_val = 32'd0;
    logic [31:0] in_rs2_val = 32'd0;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_operand1, out_operand2;
    logic [3:0]  out_alu_opcode;
    logic [4:0]  out_rd;
    logic [15:0] illegal_count;

    logic        s_in_ready, s_out_valid, s_out_illegal;
    logic [31:0] s_out_operand1, s_out_operand2;
    logic [3:0]  s_out_alu_opcode;
    logic [4:0]  s_out_rd;
    logic [1:0]  s_count;

    int passed = 0;
    int total = 0;
    int failed = 0;

    logic [73:0] q[$];

    alu_issue_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_operand1(out_operand1),
        .out_operand2(out_operand2), .out_alu_opcode(out_alu_opcode), .out_rd(out_rd),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    alu_issue_stage #(.WIDTH(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_operand1(s_out_operand1),
        .out_operand2(s_out_operand2), .out_alu_opcode(s_out_alu_opcode), .out_rd(s_out_rd),
        .out_illegal(s_out_illegal), .illegal_count(s_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [73:0] pl(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] op, input logic [4:0] rd,
                                       input logic ill);
        return {a, b, op, rd, ill};
    endfunction

    function automatic logic [73:0] observed();
        return {out_operand1, out_operand2, out_alu_opcode, out_rd, out_illegal};
    endfunction

    // Reference decode written straight from the instruction table.
    function automatic logic [73:0] ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic [3:0]  op  = 4'd0;
        logic [31:0] o2  = b;
        if (opc == 7'b0110011) begin
            if (f7 == 7'b0000000) begin
                if (f3 == 3'b000) op = 4'd1;
                if (f3 == 3'b111) op = 4'd3;
                if (f3 == 3'b110) op = 4'd4;
                if (f3 == 3'b100) op = 4'd5;
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                op = 4'd2;
            end
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'b000) op = 4'd1;
            if (f3 == 3'b111) op = 4'd3;
            if (f3 == 3'b110) op = 4'd4;
            if (f3 == 3'b100) op = 4'd5;
            if (op != 4'd0) o2 = 32'($signed(ins[31:20]));
        end
        return {a, o2, op, ins[11:7], (op == 4'd0)};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid   = v;
        in_instr   = ins;
        in_rs1_val = a;
        in_rs2_val = b;
    endtask

    initial begin
        int n_ill;
        int accepted;
        int cycles;
        int k;
        bit pop;
        bit push;
        logic [73:0] item;
        logic [2:0]  f3r;
        logic [6:0]  f7r;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", out_valid, 74'd0);
        check("rst_in_ready", in_ready, 74'd1);
        check("rst_count", illegal_count, 74'd0);
        check("rst_payload", observed(), 74'd0);
        rst_n = 1'b1;

        // 1: add x3,x1,x2
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
        @(negedge clk);
        check("t1_valid", out_valid, 74'd1);
        check("t1_payload", observed(), pl(32'd5, 32'd7, 4'b0001, 5'd3, 1'b0));
        // 2: addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'd10, 32'd99);
        @(negedge clk);
        check("t2_payload", observed(), pl(32'd10, 32'hFFFFFFFF, 4'b0001, 5'd1, 1'b0));
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("t2_drain", out_valid, 74'd0);

        // 3: sub then xori back-to-back with the ALU stalled
        out_ready = 1'b0;
        drive(1'b1, 32'h40208133, 32'd100, 32'd30);
        @(negedge clk);
        check("t3_ready_first", in_ready, 74'd1);
        check("t3_sub", observed(), pl(32'd100, 32'd30, 4'b0010, 5'd2, 1'b0));
        drive(1'b1, 32'h0F02C313, 32'h55, 32'h1234);
        @(negedge clk);
        check("t3_skid_full", in_ready, 74'd0);
        check("t3_sub_stalled", observed(), pl(32'd100, 32'd30, 4'b0010, 5'd2, 1'b0));
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("t3_sub_hold", observed(), pl(32'd100, 32'd30, 4'b0010, 5'd2, 1'b0));
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_xor_valid", out_valid, 74'd1);
        check("t3_xor", observed(), pl(32'h55, 32'h0F0, 4'b0101, 5'd6, 1'b0));
        check("t3_ready_back", in_ready, 74'd1);
        @(negedge clk);
        check("t3_drain", out_valid, 74'd0);

        // 4: illegal instructions and counter saturation
        drive(1'b1, 32'h00000000, 32'd1, 32'd2);
        @(negedge clk);
        check("t4_illegal", observed(), pl(32'd1, 32'd2, 4'b0000, 5'd0, 1'b1));
        @(negedge clk);
        @(negedge clk);
        check("t4_count3", illegal_count, 74'd3);
        check("t4_small3", s_count, 74'd3);
        @(negedge clk);
        @(negedge clk);
        check("t4_count5", illegal_count, 74'd5);
        check("t4_small_sat", s_count, 74'd3);

        // 6: reset with both registers full
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd11, 32'd22);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        check("t6_full", in_ready, 74'd0);
        check("t6_valid", out_valid, 74'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 74'd0);
        check("t6_async_count", illegal_count, 74'd0);
        check("t6_async_small", s_count, 74'd0);
        check("t6_async_payload", observed(), 74'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after", in_ready, 74'd1);
        check("t6_valid_after", out_valid, 74'd0);

        // 5: random traffic against the queue model
        n_ill = 0;
        accepted = 0;
        cycles = 0;
        push = 1'b0;
        while (accepted < 10000 && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            check("rnd_out_valid", out_valid, 74'(q.size() > 0));
            check("rnd_in_ready", in_ready, 74'(q.size() < 2));
            if (q.size() > 0) check("rnd_payload", observed(), q[0]);
            check("rnd_count", illegal_count, 74'((n_ill > 65535) ? 65535 : n_ill));
            check("rnd_small", s_count, 74'((n_ill > 3) ? 3 : n_ill));
            if (push) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && ($urandom_range(0, 3) != 0)) begin
                k   = $urandom_range(0, 3);
                f3r = 3'($urandom);
                f7r = ($urandom_range(0, 2) == 0) ? 7'b0100000 : 7'b0000000;
                case (k)
                    0: in_instr = {f7r, 10'($urandom), f3r, 5'($urandom), 7'b0110011};
                    1: in_instr = {12'($urandom), 5'($urandom), f3r, 5'($urandom), 7'b0010011};
                    2: in_instr = $urandom;
                    default: in_instr = {7'($urandom), 10'($urandom), f3r, 5'($urandom), 7'b0110011};
                endcase
                in_rs1_val = $urandom;
                in_rs2_val = $urandom;
                in_valid   = 1'b1;
            end
            pop  = (q.size() > 0) && out_ready;
            push = in_valid && (q.size() < 2);
            if (pop) void'(q.pop_front());
            if (push) begin
                item = ref_decode(in_instr, in_rs1_val, in_rs2_val);
                q.push_back(item);
                if (item[0]) n_ill++;
                accepted++;
            end
        end
        check("rnd_budget", 74'(accepted >= 10000), 74'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
